// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with wrap-bit pointers, an occupancy counter, and almost-full/almost-empty flags.
// The read port is either registered (FWFT=0) or first-word-fall-through (FWFT=1).
module sync_fifo_param #(
    parameter int WIDTH          = 8,
    parameter int DEPTH          = 16,
    parameter int ADDR_PTR_WIDTH = 4,
    parameter int AF_THRESH      = 14,
    parameter int AE_THRESH      = 2,
    parameter int FWFT           = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clr,
    input  logic                      wr_en,
    input  logic [WIDTH-1:0]          w_data,
    input  logic                      rd_en,
    output logic [WIDTH-1:0]          r_data,
    output logic                      full,
    output logic                      empty,
    output logic                      almost_full,
    output logic                      almost_empty,
    output logic [ADDR_PTR_WIDTH:0]   count,
    output logic                      wr_err,
    output logic                      rd_err
);

    localparam int AW = ADDR_PTR_WIDTH;
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0] AF_LVL  = AF_THRESH[AW:0];
    localparam logic [AW:0] AE_LVL  = AE_THRESH[AW:0];

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [AW:0]      r_count;
    logic             r_wr_err;
    logic             r_rd_err;

    logic             w_full;
    logic             w_empty;
    logic             w_wr_acc;
    logic             w_rd_acc;

    // Handshake: wr_en/rd_en are requests; the FIFO is "ready" when not full / not empty.
    // A request is accepted at an edge only if ready then; a refused request pulses *_err next cycle.
    assign w_full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_empty  = (r_wr_ptr == r_rd_ptr);
    assign w_wr_acc = wr_en && !w_full && !clr;
    assign w_rd_acc = rd_en && !w_empty && !clr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_wr_err <= 1'b0;
            r_rd_err <= 1'b0;
        end else if (clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_wr_err <= 1'b0;
            r_rd_err <= 1'b0;
        end else begin
            r_wr_err <= wr_en && w_full;
            r_rd_err <= rd_en && w_empty;
            if (w_wr_acc) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_rd_acc) r_rd_ptr <= r_rd_ptr + PTR_ONE;
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + PTR_ONE;
                2'b01:   r_count <= r_count - PTR_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is deliberately left out of reset and flush.
    always_ff @(posedge clk) begin
        if (w_wr_acc) r_mem[r_wr_ptr[AW-1:0]] <= w_data;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign r_data = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
        end else begin : g_reg_read
            logic [WIDTH-1:0] r_rdata;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)        r_rdata <= '0;
                else if (w_rd_acc) r_rdata <= r_mem[r_rd_ptr[AW-1:0]];
            end
            assign r_data = r_rdata;
        end
    endgenerate

    assign full         = w_full;
    assign empty        = w_empty;
    assign count        = r_count;
    assign almost_full  = (r_count >= AF_LVL);
    assign almost_empty = (r_count <= AE_LVL);
    assign wr_err       = r_wr_err;
    assign rd_err       = r_rd_err;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: one registered-read and one FWFT instance share stimulus,
// and both are compared every cycle against a queue-based reference model.
module tb_sync_fifo_param;

    localparam int W = 8;
    localparam int D = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         clr = 1'b0;
    logic         wr_en = 1'b0;
    logic [W-1:0] w_data = '0;
    logic         rd_en = 1'b0;

    logic [W-1:0] r_data0, r_data1;
    logic         full0, empty0, af0, ae0, werr0, rerr0;
    logic         full1, empty1, af1, ae1, werr1, rerr1;
    logic [4:0]   count0, count1;

    int n_cmp = 0;
    int n_bad = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_rd0;
    bit           exp_werr;
    bit           exp_rerr;

    sync_fifo_param #(.FWFT(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .wr_en(wr_en), .w_data(w_data), .rd_en(rd_en),
        .r_data(r_data0), .full(full0), .empty(empty0), .almost_full(af0), .almost_empty(ae0),
        .count(count0), .wr_err(werr0), .rd_err(rerr0)
    );

    sync_fifo_param #(.FWFT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .wr_en(wr_en), .w_data(w_data), .rd_en(rd_en),
        .r_data(r_data1), .full(full1), .empty(empty1), .almost_full(af1), .almost_empty(ae1),
        .count(count1), .wr_err(werr1), .rd_err(rerr1)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        exp_rd0  = '0;
        exp_werr = 1'b0;
        exp_rerr = 1'b0;
    endtask

    // Reference behaviour per edge: decisions use the occupancy before the edge.
    task automatic model_edge(input bit we, input logic [W-1:0] d, input bit re, input bit cl);
        int n;
        if (cl) begin
            exp_q.delete();
            exp_werr = 1'b0;
            exp_rerr = 1'b0;
        end else begin
            n = exp_q.size();
            exp_werr = we && (n == D);
            exp_rerr = re && (n == 0);
            if (re && n != 0) exp_rd0 = exp_q.pop_front();
            if (we && n != D) exp_q.push_back(d);
        end
    endtask

    task automatic check_outputs(input string ctx);
        int n;
        logic [W-1:0] fw;
        n  = exp_q.size();
        fw = (n == 0) ? '0 : exp_q[0];
        check_eq({ctx, ".count"},  32'(count0), 32'(n));
        check_eq({ctx, ".full"},   32'(full0),  32'(n == D));
        check_eq({ctx, ".empty"},  32'(empty0), 32'(n == 0));
        check_eq({ctx, ".af"},     32'(af0),    32'(n >= 14));
        check_eq({ctx, ".ae"},     32'(ae0),    32'(n <= 2));
        check_eq({ctx, ".wr_err"}, 32'(werr0),  32'(exp_werr));
        check_eq({ctx, ".rd_err"}, 32'(rerr0),  32'(exp_rerr));
        check_eq({ctx, ".rdata"},  32'(r_data0), 32'(exp_rd0));
        check_eq({ctx, ".f_count"}, 32'(count1), 32'(n));
        check_eq({ctx, ".f_empty"}, 32'(empty1), 32'(n == 0));
        check_eq({ctx, ".f_full"},  32'(full1),  32'(n == D));
        check_eq({ctx, ".f_errs"},  32'({werr1, rerr1}), 32'({exp_werr, exp_rerr}));
        check_eq({ctx, ".f_flags"}, 32'({af1, ae1}), 32'({n >= 14, n <= 2}));
        check_eq({ctx, ".f_rdata"}, 32'(r_data1), 32'(fw));
    endtask

    // Inputs change at the falling edge; outputs are checked at the next falling edge.
    task automatic step(input string ctx, input bit we, input logic [W-1:0] d, input bit re, input bit cl);
        wr_en  = we;
        w_data = d;
        rd_en  = re;
        clr    = cl;
        @(posedge clk);
        model_edge(we, d, re, cl);
        @(negedge clk);
        wr_en = 1'b0;
        rd_en = 1'b0;
        clr   = 1'b0;
        check_outputs(ctx);
    endtask

    initial begin
        int wr_left, rd_left, wr_gap, rd_gap, cycles;
        bit we, re;

        model_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_outputs("reset");
        rst_n = 1'b1;

        for (int i = 1; i <= 16; i++) step("fill", 1'b1, W'(i), 1'b0, 1'b0);
        step("fill_over", 1'b1, 8'h11, 1'b0, 1'b0);
        step("fill_idle", 1'b0, 8'h00, 1'b0, 1'b0);

        for (int i = 1; i <= 16; i++) step("drain", 1'b0, 8'h00, 1'b1, 1'b0);
        step("drain_under", 1'b0, 8'h00, 1'b1, 1'b0);
        step("drain_idle", 1'b0, 8'h00, 1'b0, 1'b0);

        step("fwft_wr", 1'b1, 8'hA5, 1'b0, 1'b0);
        step("fwft_rd", 1'b0, 8'h00, 1'b1, 1'b0);
        step("empty_wr_rd", 1'b1, 8'h5A, 1'b1, 1'b0);
        step("empty_wr_rd2", 1'b1, 8'h66, 1'b1, 1'b0);

        wr_left = 200;
        rd_left = 200;
        wr_gap  = $urandom_range(1, 8);
        rd_gap  = $urandom_range(1, 12);
        cycles  = 0;
        while ((wr_left > 0 || rd_left > 0) && cycles < 20000) begin
            we = 1'b0;
            re = 1'b0;
            if (wr_left > 0) begin
                if (wr_gap <= 1) begin
                    we = 1'b1;
                    wr_left--;
                    wr_gap = $urandom_range(1, 8);
                end else wr_gap--;
            end
            if (rd_left > 0) begin
                if (rd_gap <= 1) begin
                    re = 1'b1;
                    rd_left--;
                    rd_gap = $urandom_range(1, 12);
                end else rd_gap--;
            end
            step("rand", we, W'($urandom), re, 1'b0);
            cycles++;
        end
        check_eq("rand_done", 32'(wr_left + rd_left), 32'd0);

        step("flush0", 1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) step("refill", 1'b1, W'($urandom), 1'b0, 1'b0);
        step("full_wr_rd", 1'b1, 8'hEE, 1'b1, 1'b0);
        step("top_up", 1'b1, 8'h77, 1'b0, 1'b0);
        step("clr_full", 1'b1, 8'h99, 1'b1, 1'b1);
        step("after_clr", 1'b0, 8'h00, 1'b0, 1'b0);

        for (int i = 0; i < 5; i++) step("burst", 1'b1, W'($urandom), i[0], 1'b0);
        wr_en  = 1'b1;
        w_data = 8'hC3;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("async_rst");
        wr_en = 1'b0;
        @(negedge clk);
        check_outputs("in_rst");
        rst_n = 1'b1;
        step("post_rst_wr", 1'b1, 8'h3C, 1'b0, 1'b0);
        step("post_rst_rd", 1'b0, 8'h00, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
